// File: rtl/sram_bist_master.sv
// Wishbone classic BIST master: three-phase march over an SRAM slave, first-failure capture.
// Optional ack timeout is enabled by defining SRAM_BIST_TIMEOUT_EN.
module sram_bist_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WORDS     = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] fail_addr_o,
  output logic [31:0] fail_data_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [2:0] {IDLE, P0_WR, P1_RD, P1_WR, P2_RD, DONE} state_t;

  localparam logic [31:0] LAST_IDX = 32'(WORDS - 1);

  state_t      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] seed_q, seed_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d, timeout_q, timeout_d;
  logic [31:0] fail_addr_q, fail_addr_d, fail_data_q, fail_data_d;
`ifdef SRAM_BIST_TIMEOUT_EN
  logic [7:0]  wait_q, wait_d;
`endif

  function automatic logic [31:0] pat0(input logic [31:0] seed, input logic [31:0] idx);
    return seed ^ idx;
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] idx);
    return BASE_ADDR + (idx << 2);
  endfunction

  // Next-state: each transfer is strobe-until-ack followed by one idle gap cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
`ifdef SRAM_BIST_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          seed_d      = seed_i;
          idx_d       = 32'd0;
          state_d     = P0_WR;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_addr_d = 32'd0;
          fail_data_d = 32'd0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = 1'b1;
          adr_d       = BASE_ADDR;
          dat_d       = seed_i;
        end else begin
          state_d = state_q;
        end
      end
      P0_WR, P1_RD, P1_WR, P2_RD: begin
        if (!stb_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          adr_d = addr_of(idx_q);
          we_d  = (state_q == P0_WR) || (state_q == P1_WR);
          dat_d = (state_q == P1_WR) ? ~pat0(seed_q, idx_q) : pat0(seed_q, idx_q);
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
`ifdef SRAM_BIST_TIMEOUT_EN
          wait_d = 8'd0;
`endif
          case (state_q)
            P0_WR: begin
              if (idx_q == LAST_IDX) begin
                state_d = P1_RD;
                idx_d   = 32'd0;
              end else begin
                idx_d = idx_q + 32'd1;
              end
            end
            P1_RD: begin
              if (wbm_dat_i != pat0(seed_q, idx_q)) begin
                fail_d      = 1'b1;
                fail_addr_d = adr_q;
                fail_data_d = wbm_dat_i;
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
              end else begin
                state_d = P1_WR;
              end
            end
            P1_WR: begin
              if (idx_q == LAST_IDX) begin
                state_d = P2_RD;
              end else begin
                state_d = P1_RD;
                idx_d   = idx_q + 32'd1;
              end
            end
            P2_RD: begin
              if (wbm_dat_i != ~pat0(seed_q, idx_q)) begin
                fail_d      = 1'b1;
                fail_addr_d = adr_q;
                fail_data_d = wbm_dat_i;
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
              end else if (idx_q == 32'd0) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q - 32'd1;
              end
            end
            default: state_d = DONE;
          endcase
        end else begin
`ifdef SRAM_BIST_TIMEOUT_EN
          // The 255th consecutive cycle without ack abandons the pending transfer.
          if (wait_q == 8'd254) begin
            wait_d      = 8'd0;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            fail_d      = 1'b1;
            timeout_d   = 1'b1;
            fail_addr_d = adr_q;
            fail_data_d = 32'd0;
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
`else
          state_d = state_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      idx_q       <= 32'd0;
      seed_q      <= 32'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= 32'd0;
      fail_data_q <= 32'd0;
`ifdef SRAM_BIST_TIMEOUT_EN
      wait_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
`ifdef SRAM_BIST_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
`ifdef SRAM_BIST_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = 4'hF;

endmodule

// File: tb/tb_sram_bist_master.sv
// Directed bench for sram_bist_master (WORDS=16) against a 16-word SRAM model with zero-wait ack.
module tb_sram_bist_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start_i  = 1'b0;
  logic [31:0] seed_i   = 32'd0;
  logic        busy_o, done_o, fail_o, timeout_o;
  logic [31:0] fail_addr_o, fail_data_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  sram_bist_master #(.BASE_ADDR(32'h3000_0000), .WORDS(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // SRAM model: mode 1 flips bit 0 on first read of word 5, mode 2 inverts second read of word 0
  logic [31:0] mem [16];
  int          rd_cnt [16];
  int          mode     = 0;
  logic        hold_en  = 1'b0;
  logic [3:0]  hold_idx = 4'd0;
  logic        clr      = 1'b0;
  int          xfers    = 0;
  int          proto_err = 0;
  logic        prev_ack = 1'b0;
  logic [3:0]  m_idx;

  assign m_idx     = wbm_adr_o[5:2];
  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~(hold_en & (m_idx == hold_idx) & wbm_we_o);

  always_comb begin
    wbm_dat_i = mem[m_idx];
    if (mode == 1 && m_idx == 4'd5 && rd_cnt[m_idx] == 0) wbm_dat_i = wbm_dat_i ^ 32'd1;
    else if (mode == 2 && m_idx == 4'd0 && rd_cnt[m_idx] == 1) wbm_dat_i = ~wbm_dat_i;
    else wbm_dat_i = wbm_dat_i;
  end

  always @(posedge wb_clk_i) begin
    if (clr) begin
      xfers <= 0;
      proto_err <= 0;
      for (int i = 0; i < 16; i++) rd_cnt[i] <= 0;
    end else begin
      if (wbm_ack_i) begin
        xfers <= xfers + 1;
        if (wbm_we_o) mem[m_idx] <= wbm_dat_o;
        else rd_cnt[m_idx] <= rd_cnt[m_idx] + 1;
      end
      if (wbm_stb_o && (prev_ack || wbm_sel_o != 4'hF || wbm_adr_o[31:6] != 26'h0C0_0000))
        proto_err <= proto_err + 1;
    end
    prev_ack <= wbm_ack_i;
  end

  int total = 0;
  int bad   = 0;
  int cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] seed);
    clr = 1'b1;
    @(posedge wb_clk_i); #1;
    clr = 1'b0;
    start_i = 1'b1;
    seed_i = seed;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
    chk("first_xfer", {27'd0, busy_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, done_o}, 32'h0000_001E);
    chk("first_adr", wbm_adr_o, 32'h3000_0000);
    chk("first_dat", wbm_dat_o, seed);
  endtask

  // Counts cycles from the start edge (inclusive) to the edge that raises done_o.
  task automatic wait_done(input int inject_at, output int cyc);
    cyc = 1;
    while (!done_o && cyc < 2000) begin
      start_i = (cyc == inject_at) ? 1'b1 : 1'b0;
      seed_i  = (cyc == inject_at) ? 32'hFFFF_FFFF : seed_i;
      @(posedge wb_clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_reached", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    #23;
    chk("rst_ctrl", {24'd0, busy_o, done_o, fail_o, timeout_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, 1'b0}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_fail_addr", fail_addr_o, 32'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    // clean run with an ignored start pulse in the middle
    mode = 0;
    start_run(32'hA5A5_0000);
    wait_done(40, cycles);
    chk("clean_cycles", cycles, 32'd128);
    chk("clean_xfers", xfers, 32'd64);
    chk("clean_status", {29'd0, busy_o, fail_o, timeout_o}, 32'd0);
    chk("clean_proto", proto_err, 32'd0);
    chk("clean_mem7", mem[7], 32'h5A5A_FFF8);
    chk("clean_bus_idle", {31'd0, wbm_cyc_o}, 32'd0);

    // P1 corruption of word 5
    mode = 1;
    start_run(32'hA5A5_0000);
    wait_done(0, cycles);
    chk("p1_cycles", cycles, 32'd54);
    chk("p1_fail", {31'd0, fail_o}, 32'd1);
    chk("p1_fail_addr", fail_addr_o, 32'h3000_0014);
    chk("p1_fail_data", fail_data_o, 32'hA5A5_0004);
    repeat (10) @(posedge wb_clk_i);
    #1;
    chk("p1_xfers_after", xfers, 32'd27);
    chk("p1_status_held", {30'd0, done_o, fail_o}, 32'd3);

    // P2 stuck-at on word 0
    mode = 2;
    start_run(32'hA5A5_0000);
    wait_done(0, cycles);
    chk("p2_fail", {31'd0, fail_o}, 32'd1);
    chk("p2_fail_addr", fail_addr_o, 32'h3000_0000);
    chk("p2_fail_data", fail_data_o, 32'hA5A5_0000);
    chk("p2_xfers_before_fail", xfers - 1, 32'd63);
    chk("p2_timeout", {31'd0, timeout_o}, 32'd0);

    // reset during P1, then a clean rerun
    mode = 0;
    start_run(32'h1234_5678);
    cycles = 0;
    while (xfers < 20 && cycles < 500) begin
      @(posedge wb_clk_i); #1;
      cycles++;
    end
    chk("midrst_reached", {31'd0, xfers >= 20}, 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("midrst_drop", {29'd0, wbm_cyc_o, wbm_stb_o, busy_o}, 32'd0);
    @(posedge wb_clk_i); #2;
    wb_rst_i = 1'b0;
    start_run(32'h1234_5678);
    wait_done(0, cycles);
    chk("rerun_cycles", cycles, 32'd128);
    chk("rerun_xfers", xfers, 32'd64);
    chk("rerun_fail", {31'd0, fail_o}, 32'd0);

`ifdef SRAM_BIST_TIMEOUT_EN
    // ack withheld on the P0 write of word 3
    hold_en = 1'b1;
    hold_idx = 4'd3;
    start_run(32'hA5A5_0000);
    wait_done(0, cycles);
    hold_en = 1'b0;
    chk("to_cycles", cycles, 32'd262);
    chk("to_flags", {30'd0, fail_o, timeout_o}, 32'd3);
    chk("to_fail_addr", fail_addr_o, 32'h3000_000C);
    chk("to_fail_data", fail_data_o, 32'd0);
    chk("to_bus_idle", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
